alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_muldiv_iter.sv | 99 +++++++++
 rtl/alu_mc.sv | 141 ++++++++++++++
 tb/tb_alu_mc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode classification helpers for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13,
    OP_RSV0  = 4'd14,
    OP_RSV1  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iter_op(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // Ops whose result lives in the upper half of the working register.
  function automatic logic is_hi_op(input alu_op_e op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle over a 2*XLEN register.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;

  logic [PW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            div_q, div_d;
  logic            hi_q, hi_d;
  logic            done_q, done_d;
  logic            start_div_c;

  // One iteration: mul = {hi, multiplier}; div = {remainder, dividend/quotient}.
  function automatic logic [PW-1:0] step(input logic [PW-1:0]   acc,
                                         input logic [XLEN-1:0] opnd,
                                         input logic            is_div);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] rem_sub;
    logic            ge;
    if (is_div) begin
      shifted = {acc[PW-1:XLEN], acc[XLEN-1]};
      ge      = (shifted >= {1'b0, opnd});
      rem_sub = shifted[XLEN-1:0] - opnd;
      step    = {(ge ? rem_sub : shifted[XLEN-1:0]), acc[XLEN-2:0], ge};
    end else begin
      sum  = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : (XLEN+1)'(0));
      step = {sum, acc[XLEN-1:1]};
    end
  endfunction

  assign start_div_c = is_div_op(op);

  // The load cycle performs the first iteration, so done pulses after XLEN steps.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    div_d  = div_q;
    hi_d   = hi_q;
    done_d = 1'b0;
    if (start) begin
      div_d  = start_div_c;
      hi_d   = is_hi_op(op);
      opnd_d = start_div_c ? b : a;
      acc_d  = step({XLEN'(0), (start_div_c ? a : b)}, (start_div_c ? b : a), start_div_c);
      cnt_d  = CW'(1);
      run_d  = 1'b1;
    end else if (run_q) begin
      acc_d = step(acc_q, opnd_q, div_q);
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(XLEN - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      done_q <= done_d;
    end
  end

  assign done   = done_q;
  assign result = hi_q ? acc_q[PW-1:XLEN] : acc_q[XLEN-1:0];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops in place, mul/div through the iterative unit.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            zero,
  output logic            busy
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] y_q, y_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;
  logic            start_c;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  logic            sub_c;
  logic [XLEN-1:0] b_opnd_c;
  logic [XLEN:0]   sum_c;
  logic            slt_c;
  logic            sltu_c;
  logic [XLEN-1:0] alu_c;

  // Shared adder: everything except ADD subtracts via a + ~b + 1.
  assign sub_c    = (op != OP_ADD);
  assign b_opnd_c = sub_c ? ~b : b;
  assign sum_c    = {1'b0, a} + {1'b0, b_opnd_c} + (XLEN+1)'(sub_c);
  assign slt_c    = sum_c[XLEN-1] ^ ((a[XLEN-1] ^ b[XLEN-1]) & (sum_c[XLEN-1] ^ a[XLEN-1]));
  assign sltu_c   = ~sum_c[XLEN];

  always_comb begin
    alu_c = '0;
    case (op)
      OP_ADD, OP_SUB: alu_c = sum_c[XLEN-1:0];
      OP_AND:         alu_c = a & b;
      OP_OR:          alu_c = a | b;
      OP_XOR:         alu_c = a ^ b;
      OP_SLL:         alu_c = a << b[SHW-1:0];
      OP_SRL:         alu_c = a >> b[SHW-1:0];
      OP_SRA:         alu_c = $unsigned($signed(a) >>> b[SHW-1:0]);
      OP_SLT:         alu_c = XLEN'(slt_c);
      OP_SLTU:        alu_c = XLEN'(sltu_c);
      default:        alu_c = '0;
    endcase
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_c),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    start_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (is_iter_op(op)) begin
            start_c = 1'b1;
            state_d = ST_BUSY;
            busy_d  = 1'b1;
          end else begin
            y_d         = alu_c;
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          y_d         = md_result;
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign y         = y_q;
  assign zero      = (y_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table for XLEN=32 plus hold, reset and XLEN=8 sequences.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [31:0] a, b, y;
  alu_op_e     op;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero, s_busy;
  logic [7:0]  s_a, s_b, s_y;
  alu_op_e     s_op;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  alu_mc #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .busy(busy)
  );

  alu_mc #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .op(s_op), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .y(s_y), .zero(s_zero), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency and busy cycles, then consume the result.
  task automatic run_op(input alu_op_e o, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] yv, output logic zv, output int lat, output int bcnt);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_wait", 64'(in_ready), 64'(1));
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = OP_XOR; a = 32'hDEADBEEF; b = 32'h0BADF00D;
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    yv = y; zv = zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op8(input alu_op_e o, input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] yv, output int lat);
    int guard;
    guard = 0;
    while (!s_in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_wait8", 64'(s_in_ready), 64'(1));
    s_op = o; s_a = av; s_b = bv; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_a = 8'hA5; s_b = 8'h3C;
    lat = 1;
    while (!s_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    yv = s_y;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] yv;
    logic [7:0]  yv8;
    logic        zv;
    int          lat, bc;

    vecs[0]  = '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1};
    vecs[1]  = '{OP_SUB,   32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1};
    vecs[2]  = '{OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1};
    vecs[3]  = '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
    vecs[4]  = '{OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1};
    vecs[5]  = '{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1};
    vecs[6]  = '{OP_SLL,   32'h00000001, 32'h00000023, 32'h00000008, 1};
    vecs[7]  = '{OP_SRL,   32'h80000000, 32'h00000004, 32'h08000000, 1};
    vecs[8]  = '{OP_SRA,   32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1};
    vecs[9]  = '{OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
    vecs[10] = '{OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vecs[11] = '{OP_RSV0,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1};
    vecs[12] = '{OP_MUL,   32'h12345678, 32'h00000010, 32'h23456780, 33};
    vecs[13] = '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[14] = '{OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 33};
    vecs[15] = '{OP_REMU,  32'd100,      32'd0,        32'd100,      33};
    vecs[16] = '{OP_DIVU,  32'd100,      32'd7,        32'd14,       33};
    vecs[17] = '{OP_REMU,  32'd100,      32'd7,        32'd2,        33};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = OP_ADD;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_op = OP_ADD;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_y", 64'(y), 64'(0));
    check("rst_zero", 64'(zero), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, yv, zv, lat, bc);
      check($sformatf("vec%0d_y", i), 64'(yv), 64'(vecs[i].exp));
      check($sformatf("vec%0d_zero", i), 64'(zv), 64'(vecs[i].exp == 32'd0));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), 64'(bc), 64'(vecs[i].lat - 1));
    end

    // Result held in DONE while a competing request is presented.
    op = OP_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    op = OP_SUB; a = 32'd100; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_y", i), 64'(y), 64'(7));
      check($sformatf("hold%0d_valid", i), 64'(out_valid), 64'(1));
      check($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("hold_after_valid", 64'(out_valid), 64'(0));
    check("hold_after_in_ready", 64'(in_ready), 64'(1));
    check("hold_after_y", 64'(y), 64'(7));
    @(posedge clk); #1;
    check("hold_no_accept", 64'(out_valid), 64'(0));

    // Asynchronous reset in the 10th BUSY cycle.
    op = OP_MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("midrst_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_y", 64'(y), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    run_op(OP_DIVU, 32'd100, 32'd7, yv, zv, lat, bc);
    check("postrst_divu_y", 64'(yv), 64'(14));
    check("postrst_divu_lat", 64'(lat), 64'(33));

    run_op8(OP_MUL, 8'd15, 8'd17, yv8, lat);
    check("x8_mul_y", 64'(yv8), 64'(8'hFF));
    check("x8_mul_lat", 64'(lat), 64'(9));
    run_op8(OP_REMU, 8'd200, 8'd7, yv8, lat);
    check("x8_remu_y", 64'(yv8), 64'(4));
    run_op8(OP_MULHU, 8'd200, 8'd200, yv8, lat);
    check("x8_mulhu_y", 64'(yv8), 64'(8'h9C));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
